// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Provides the FSM state encoding and the bit-counter width helper.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter must hold values 0..width, hence width+1 codes.
    function automatic int sub_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub_1_bit.sv
// Gate-level 1-bit full subtractor: dif = in1 - in2 - bin.
// Ports: in1/in2 operand bits, bin borrow-in; dif difference, bout borrow-out.
module sub_1_bit (
    input  logic in1,
    input  logic in2,
    input  logic bin,
    output logic dif,
    output logic bout
);

    wire w_x;
    wire w_dif;
    wire w_n1;
    wire w_nx;
    wire w_p;
    wire w_q;
    wire w_bout;

    xor g_x1 (w_x, in1, in2);
    xor g_x2 (w_dif, w_x, bin);

    // Borrow when in1=0,in2=1, or when the bits are equal and a borrow arrives.
    not g_n1 (w_n1, in1);
    and g_a1 (w_p, w_n1, in2);
    not g_n2 (w_nx, w_x);
    and g_a2 (w_q, w_nx, bin);
    or  g_o1 (w_bout, w_p, w_q);

    assign dif  = w_dif;
    assign bout = w_bout;

endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: o_diff = i_a - i_b - i_bin, LSB first.
// Ports: i_clk, i_rst (sync, active-high), i_start/o_ready/o_done handshake,
//        i_a/i_b/i_bin operands, o_diff result, o_borrow_out final borrow.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out
);

    import sub_serial_pkg::*;

    localparam int CW = sub_cnt_w(WIDTH);

    sub_state_t       r_state;
    sub_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] w_diff_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_bo;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic             w_accept;

    sub_1_bit u_cell (
        .in1  (r_sa[0]),
        .in2  (r_sb[0]),
        .bin  (r_br),
        .dif  (w_d),
        .bout (w_bo)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // New result bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    always_comb begin
        w_diff_nxt            = r_diff >> 1;
        w_diff_nxt[WIDTH-1]   = w_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_bo   <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= i_a;
            r_sb  <= i_b;
            r_br  <= i_bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_sa   <= r_sa >> 1;
            r_sb   <= r_sb >> 1;
            r_br   <= w_bo;
            r_diff <= w_diff_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_bo <= w_bo;
            end
        end
    end

    assign o_diff       = r_diff;
    assign o_borrow_out = r_bo;

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial unsigned subtractor computing `a - b - bin` one bit per clock, LSB first, with a borrow flip-flop carried between cycles. It is the subtraction counterpart to the team's 1-bit adder cell. It sits in the arithmetic datapath wherever area matters more than latency, and chains through `bin`/`borrow_out` for wider operands. A start/ready/done handshake frames each operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range WIDTH >= 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  WIDTH  minuend, latched on accepted start.
- `b`  in  WIDTH  subtrahend, latched on accepted start.
- `bin`  in  1  borrow-in, latched on accepted start.
- `ready`  out  1  high in IDLE; start accepted when `start & ready`.
- `done`  out  1  single-cycle pulse; `diff`/`borrow_out` valid from this cycle.
- `diff`  out  WIDTH  result `(a - b - bin) mod 2^WIDTH`.
- `borrow_out`  out  1  1 iff `a < b + bin` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `ready`=1. On `start`, latch `a`→`sa`, `b`→`sb`, `bin`→borrow reg `br`, clear bit counter `cnt`, then go to RUN.
  - RUN: per cycle compute `d = sa[0]^sb[0]^br` and `bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)`. Shift `d` into result register MSB (right shift). Shift `sa`, `sb` right by 1. Set `br<=bo`. Increment `cnt`. When `cnt == WIDTH-1` at the edge, go to DONE.
  - DONE: `done`=1 for exactly one cycle. Go to IDLE unconditionally.
- Result register drives `diff` directly. `borrow_out` is a register loaded from `bo` on the final RUN edge.
- `diff`/`borrow_out` hold their value from DONE until the next accepted start. They may change during RUN, so consumers sample only on `done`.
- `start` is ignored in RUN and DONE; no queuing.
- `ready` and `done` are decoded combinationally from the state register only.
- `cnt` width is `$clog2(WIDTH+1)`. WIDTH=1 takes one RUN cycle.
- Reset at any time, including mid-RUN or in DONE, aborts the operation: no `done` pulse, all registers cleared, state IDLE.

## Timing
- Reset values: `ready`=1, `done`=0, `diff`=0, `borrow_out`=0, state IDLE, `cnt`=0, `br`=0.
- Start sampled high in cycle 0 → RUN in cycles 1..WIDTH → `done` high in cycle WIDTH+1. Latency is WIDTH+1 cycles.
- `ready` is high again in cycle WIDTH+2. Minimum issue interval is WIDTH+2 cycles.
- `start` held high continuously causes back-to-back operations at the minimum interval, with operands resampled at each acceptance.
- `start` and `rst` in the same cycle: reset wins, start is dropped.

## Structure
- Package `sub_serial_pkg`:
  - state enum typedef `sub_state_t` {IDLE, RUN, DONE}.
  - helper constant or function for counter width.
- Sub-module `sub_1_bit` (ports `in1`, `in2`, `bin`, `dif`, `bout`): gate-level full subtractor built from xor/and/or/not primitives, mirroring the adder cell style. Instantiate it once for the per-cycle bit.
- Top level holds the FSM, counter, shift registers and borrow flip-flop.

## Test plan
- Reset: hold `rst` 2 cycles → `ready`=1, `done`=0, `diff`=0x00, `borrow_out`=0. Release → no activity without `start`.
- WIDTH=8, `a`=0x5A, `b`=0x23, `bin`=0, start in cycle 0 → `done` only in cycle 9, `diff`=0x37, `borrow_out`=0. Outputs stable through cycle 20.
- Underflow and borrow-in:
  - `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `borrow_out`=1.
  - `a`=0x10, `b`=0x10, `bin`=1 → `diff`=0xFF, `borrow_out`=1.
  - `a`=0x80, `b`=0x7F, `bin`=1 → `diff`=0x00, `borrow_out`=0.
- Ignored start: accept 0xF0-0x0F. Pulse `start` with `a`=0x01, `b`=0x02 in cycles 3 and 9 → first result 0xE1/0. Only one `done` pulse by cycle 10. `ready`=1 in cycle 10.
- Back-to-back: `start` held high with operands changed each acceptance → `done` pulses every 10 cycles, each result matching the operands latched at its acceptance.
- Mid-op reset: assert `rst` in cycle 4 of RUN → no `done`, reset values next cycle. A new start then yields a correct result. Also run a randomized sweep of 1000 operand triples against the `a-b-bin` reference model for WIDTH=1, 8 and 13.
